elite_7seg_decoder: RTL and testbench
=====================================

ELITE_7SEG_DECODER -- requirements
Module: elite_7seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16 (legal 2..255): consecutive identical samples required before a snapshot is accepted.
REQ-002 SHALL use one clock and synchronous, active-high reset: CLOCK_50  in  1  system clock; Reset_7Seg  in  1  sync active-high reset.
REQ-003 SHALL have Seg_In_0 .. Seg_In_5  in  7 each  active-low gfedcba patterns; digit 0 is far right, digit 5 far left.
REQ-004 SHALL have Dec_Word  out  24  decoded nibbles; digit n in [4n+3:4n].
REQ-005 SHALL have Dec_Valid_Mask  out  6  bit n = digit n is a recognised hex glyph.
REQ-006 SHALL have Dec_Blank_Mask  out  6  bit n = digit n is all-off (7'h7F).
REQ-007 SHALL have Dec_Update  out  1  one-cycle strobe, published outputs changed.

Function
REQ-008 SHALL register all 42 input bits into snapshot register prev every cycle.
REQ-009 SHALL keep stable counter cnt: input==prev -> cnt+1 saturating at STABLE_CYCLES; input!=prev -> cnt=0 and pending cleared.
REQ-010 SHALL raise capture event when input==prev and cnt==STABLE_CYCLES-1; one event per stable period.
REQ-011 SHALL implement FSM IDLE -> SCAN -> PUBLISH -> IDLE.
REQ-012 IDLE: on capture event or pending set, SHALL load capture register from prev, clear pending, set idx=0, go SCAN.
REQ-013 SCAN: each cycle SHALL decode capture digit idx via one decoder instance into shadow nibble/valid/blank, idx+1; after idx 5 go PUBLISH (6 cycles).
REQ-014 PUBLISH: if shadow differs from published outputs, SHALL load outputs and pulse Dec_Update for one cycle; else no pulse; go IDLE.
REQ-015 Capture event outside IDLE SHALL set pending; capture register SHALL NOT change outside IDLE.
REQ-016 Latency: new pattern first sampled at edge k, held -> capture edge k+STABLE_CYCLES, outputs and Dec_Update registered at edge k+STABLE_CYCLES+7.
REQ-017 Decode table (gfedcba, active-low) SHALL be: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-018 Pattern 1111111 SHALL give nibble 0, valid 0, blank 1; any other unlisted pattern (L, i, t, ...) nibble 0, valid 0, blank 0.
REQ-019 Dec_Update SHALL never assert in two consecutive cycles.

Reset
REQ-020 Reset SHALL force Dec_Word=0, masks=0, Dec_Update=0, FSM=IDLE, idx=0, cnt=0, pending=0, prev=all ones, capture/shadow=0.
REQ-021 Reset mid-SCAN/PUBLISH SHALL abort with no Dec_Update; reset dominates all other events in the same cycle.

Structure
REQ-022 Shared package elite_7seg_pkg SHALL hold the 16 glyph constants, blank constant, and FSM state encoding, shared with the existing display driver.
REQ-023 Sub-module elite_7seg_digit_dec SHALL be combinational: 7-bit pattern -> nibble, valid, blank; instantiated once.

Verification (STABLE_CYCLES=16)
REQ-024 Reset then inputs held 7'h7F -> one Dec_Update at edge k+23; Dec_Word 0, valid 6'h00, blank 6'h3F.
REQ-025 Digits 5..0 = glyphs 6,5,4,3,2,1 held -> single pulse, Dec_Word 24'h654321, valid 6'h3F, blank 6'h00.
REQ-026 After REQ-025, digit 0 -> glyph 9 for 5 cycles then back to 1 -> no Dec_Update, outputs unchanged.
REQ-027 Digits 5..0 = E,L,i,t,E,0 -> Dec_Word 24'hE000E0, valid 6'b100011, blank 6'h00.
REQ-028 Input change 2 cycles after capture -> old snapshot published first; new value published after re-stabilising; Reset_7Seg at SCAN cycle 3 -> no pulse, outputs 0.
REQ-029 Pattern held 1000 cycles -> exactly one Dec_Update.

Source files
------------

// File: rtl/elite_7seg_pkg.sv
// Glyph table and FSM encoding for the six-digit 7-segment snapshot decoder.
// Shared with the display driver, so the pattern constants must stay active-low gfedcba.
package elite_7seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

endpackage

// File: rtl/elite_7seg_digit_dec.sv
// Combinational single-digit decoder: active-low segment pattern to hex nibble.
// Unknown glyphs decode to 0 with valid low; all-off is flagged as blank.
module elite_7seg_digit_dec
    import elite_7seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       valid_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b1;
        blank_o  = 1'b0;
        unique case (seg_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            SEG_BLANK: begin
                valid_o = 1'b0;
                blank_o = 1'b1;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/elite_7seg_decoder.sv
// Debounced six-digit 7-segment snapshot decoder: waits for a stable input
// pattern, scans it one digit per cycle and publishes only real changes.
module elite_7seg_decoder
    import elite_7seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        CLOCK_50,
    input  logic        Reset_7Seg,
    input  logic [6:0]  Seg_In_0,
    input  logic [6:0]  Seg_In_1,
    input  logic [6:0]  Seg_In_2,
    input  logic [6:0]  Seg_In_3,
    input  logic [6:0]  Seg_In_4,
    input  logic [6:0]  Seg_In_5,
    output logic [23:0] Dec_Word,
    output logic [5:0]  Dec_Valid_Mask,
    output logic [5:0]  Dec_Blank_Mask,
    output logic        Dec_Update
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [41:0] seg_in;
    logic [41:0] prev_q, prev_d;
    logic [41:0] cap_q, cap_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] sh_word_q, sh_word_d;
    logic [5:0]  sh_valid_q, sh_valid_d;
    logic [5:0]  sh_blank_q, sh_blank_d;
    logic [23:0] word_q, word_d;
    logic [5:0]  valid_q, valid_d;
    logic [5:0]  blank_q, blank_d;
    logic        upd_q, upd_d;
    logic        same;
    logic        cap_evt;
    logic [6:0]  dig_seg;
    logic [3:0]  dig_nib;
    logic        dig_valid;
    logic        dig_blank;

    assign seg_in  = {Seg_In_5, Seg_In_4, Seg_In_3,
                      Seg_In_2, Seg_In_1, Seg_In_0};
    assign same    = (seg_in == prev_q);
    assign cap_evt = same && (cnt_q == CNT_LAST);

    always_comb begin
        unique case (idx_q)
            3'd0:    dig_seg = cap_q[6:0];
            3'd1:    dig_seg = cap_q[13:7];
            3'd2:    dig_seg = cap_q[20:14];
            3'd3:    dig_seg = cap_q[27:21];
            3'd4:    dig_seg = cap_q[34:28];
            default: dig_seg = cap_q[41:35];
        endcase
    end

    elite_7seg_digit_dec u_dec (
        .seg_i    (dig_seg),
        .nibble_o (dig_nib),
        .valid_o  (dig_valid),
        .blank_o  (dig_blank)
    );

    always_comb begin
        prev_d     = seg_in;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        state_d    = state_q;
        idx_d      = idx_q;
        sh_word_d  = sh_word_q;
        sh_valid_d = sh_valid_q;
        sh_blank_d = sh_blank_q;
        word_d     = word_q;
        valid_d    = valid_q;
        blank_d    = blank_q;
        upd_d      = 1'b0;

        if (same) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d  = 8'd0;
            pend_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cap_evt || pend_q) begin
                    cap_d   = prev_q;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                sh_word_d[{idx_q, 2'b00} +: 4] = dig_nib;
                sh_valid_d[idx_q] = dig_valid;
                sh_blank_d[idx_q] = dig_blank;
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = ST_PUBLISH;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_PUBLISH: begin
                if ({sh_word_q, sh_valid_q, sh_blank_q}
                    != {word_q, valid_q, blank_q}) begin
                    word_d  = sh_word_q;
                    valid_d = sh_valid_q;
                    blank_d = sh_blank_q;
                    upd_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A snapshot that stabilises mid-scan is remembered, not dropped
        if (cap_evt && state_q != ST_IDLE) pend_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset_7Seg) begin
            prev_q     <= '1;
            cap_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sh_word_q  <= '0;
            sh_valid_q <= '0;
            sh_blank_q <= '0;
            word_q     <= '0;
            valid_q    <= '0;
            blank_q    <= '0;
            upd_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_word_q  <= sh_word_d;
            sh_valid_q <= sh_valid_d;
            sh_blank_q <= sh_blank_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            upd_q      <= upd_d;
        end
    end

    assign Dec_Word       = word_q;
    assign Dec_Valid_Mask = valid_q;
    assign Dec_Blank_Mask = blank_q;
    assign Dec_Update     = upd_q;

endmodule

// File: tb/tb_elite_7seg_decoder.sv
// Directed bench for the 7-segment snapshot decoder (STABLE_CYCLES = 16).
module tb_elite_7seg_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  s0, s1, s2, s3, s4, s5;
    logic [23:0] word;
    logic [5:0]  vmask, bmask;
    logic        upd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elite_7seg_decoder #(.STABLE_CYCLES(16)) dut (
        .CLOCK_50       (clk),
        .Reset_7Seg     (rst),
        .Seg_In_0       (s0),
        .Seg_In_1       (s1),
        .Seg_In_2       (s2),
        .Seg_In_3       (s3),
        .Seg_In_4       (s4),
        .Seg_In_5       (s5),
        .Dec_Word       (word),
        .Dec_Valid_Mask (vmask),
        .Dec_Blank_Mask (bmask),
        .Dec_Update     (upd)
    );

    task automatic set_digits(input logic [6:0] d5, d4, d3, d2, d1, d0);
        s5 = d5; s4 = d4; s3 = d3; s2 = d2; s1 = d1; s0 = d0;
    endtask

    // edge number (1 = first edge after call) of first pulse, 0 on timeout
    task automatic wait_pulse(input int maxe, output int at);
        at = 0;
        for (int n = 1; n <= maxe; n++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) begin
                at = n;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int edges, output int pulses);
        pulses = 0;
        for (int n = 0; n < edges; n++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        int at;
        rst = 1'b1;
        set_digits(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (word !== 24'h0 || vmask !== 6'h0 || bmask !== 6'h0) begin
            failures++;
            $display("FAIL reset_out: got %h/%h/%h want 0/0/0", word, vmask, bmask);
        end
        checks++;
        if (upd !== 1'b0) begin
            failures++;
            $display("FAIL reset_upd: got %b want 0", upd);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_pulse(40, at);
        checks++;
        if (at !== 23) begin
            failures++;
            $display("FAIL blank_latency: got edge %0d want 23", at);
        end
        checks++;
        if (word !== 24'h0 || vmask !== 6'h00 || bmask !== 6'h3F) begin
            failures++;
            $display("FAIL blank_out: got %h/%h/%h want 000000/00/3f", word, vmask, bmask);
        end
    endtask

    task automatic test_glyphs();
        int at, p;
        @(negedge clk);
        set_digits(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
        wait_pulse(40, at);
        checks++;
        if (at !== 24) begin
            failures++;
            $display("FAIL glyph_latency: got edge %0d want 24", at);
        end
        checks++;
        if (word !== 24'h654321 || vmask !== 6'h3F || bmask !== 6'h00) begin
            failures++;
            $display("FAIL glyph_out: got %h/%h/%h want 654321/3f/00", word, vmask, bmask);
        end
        count_pulses(40, p);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL glyph_single: got %0d extra pulses want 0", p);
        end
    endtask

    task automatic test_glitch();
        int p;
        @(negedge clk);
        s0 = 7'h10;
        repeat (5) @(negedge clk);
        s0 = 7'h79;
        count_pulses(60, p);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL glitch_pulse: got %0d pulses want 0", p);
        end
        checks++;
        if (word !== 24'h654321 || vmask !== 6'h3F || bmask !== 6'h00) begin
            failures++;
            $display("FAIL glitch_out: got %h/%h/%h want 654321/3f/00", word, vmask, bmask);
        end
    endtask

    task automatic test_letters();
        int at;
        @(negedge clk);
        set_digits(7'h06, 7'h47, 7'h7B, 7'h07, 7'h06, 7'h40);
        wait_pulse(40, at);
        checks++;
        if (at !== 24) begin
            failures++;
            $display("FAIL letter_latency: got edge %0d want 24", at);
        end
        checks++;
        if (word !== 24'hE000E0 || vmask !== 6'b100011 || bmask !== 6'h00) begin
            failures++;
            $display("FAIL letter_out: got %h/%h/%h want e000e0/23/00", word, vmask, bmask);
        end
    endtask

    task automatic test_back_to_back();
        int first_at, second_at;
        logic [23:0] first_w, second_w;
        first_at = 0; second_at = 0;
        first_w = '0; second_w = '0;
        @(negedge clk);
        set_digits(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) begin
                if (first_at == 0) begin
                    first_at = n; first_w = word;
                end else if (second_at == 0) begin
                    second_at = n; second_w = word;
                end
            end
            if (n == 18) begin
                @(negedge clk);
                set_digits(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E);
            end
        end
        checks++;
        if (first_at !== 24 || first_w !== 24'h888888) begin
            failures++;
            $display("FAIL b2b_old: got edge %0d word %h want 24 888888", first_at, first_w);
        end
        checks++;
        if (second_at !== 42 || second_w !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL b2b_new: got edge %0d word %h want 42 ffffff", second_at, second_w);
        end
    endtask

    task automatic test_reset_mid_scan();
        int p;
        p = 0;
        @(negedge clk);
        set_digits(7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12);
        for (int n = 1; n <= 35; n++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) p++;
            if (n == 19) begin
                @(negedge clk);
                rst = 1'b1;
            end
            if (n == 20) begin
                checks++;
                if (word !== 24'h0 || vmask !== 6'h0 || bmask !== 6'h0) begin
                    failures++;
                    $display("FAIL midscan_out: got %h/%h/%h want 0/0/0", word, vmask, bmask);
                end
                @(negedge clk);
                rst = 1'b0;
            end
        end
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL midscan_pulse: got %0d pulses want 0", p);
        end
    endtask

    task automatic test_long_hold();
        int p;
        count_pulses(1000, p);
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL hold_pulses: got %0d want 1", p);
        end
        checks++;
        if (word !== 24'h555555 || vmask !== 6'h3F || bmask !== 6'h00) begin
            failures++;
            $display("FAIL hold_out: got %h/%h/%h want 555555/3f/00", word, vmask, bmask);
        end
    endtask

    initial begin
        test_reset();
        test_glyphs();
        test_glitch();
        test_letters();
        test_back_to_back();
        test_reset_mid_scan();
        test_long_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
